line_window_buffer: RTL and testbench

//   Converts a raster pixel stream read from the frame buffer into 5x5 pixel windows for the ALU.

---
 rtl/line_window_buffer.sv | 145 ++++++++++++++
 tb/tb_line_window_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/line_window_buffer.sv
// Raster pixel stream to KSxKS window converter with KS-1 line buffers and centre address.
// Optional frame counter port enabled by defining FRAME_CNT_EN.
module line_window_buffer #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240,
    parameter int DW    = 12,
    parameter int KS    = 5,
    parameter int AW    = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DW-1:0]         pix_in,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    output logic                  pix_ready,
    output logic [KS*KS*DW-1:0]   win,
    output logic                  win_valid,
    output logic [AW-1:0]         raddr_alu,
    output logic                  frame_done,
`ifdef FRAME_CNT_EN
    output logic [15:0]           frame_cnt,
`endif
    output logic                  sync_err
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e                          state_q, state_d;
    logic [CW-1:0]                   col_q, col_d, acc_col;
    logic [RW-1:0]                   row_q, row_d, acc_row;
    logic                            accept, interior;
    logic                            sync_err_d, frame_done_d;
    logic [AW-1:0]                   raddr_q, raddr_d;
    logic                            win_valid_q, frame_done_q, sync_err_q;
    // Index [0][0] is the top-left pixel so it lands in the MS slice of win.
    logic [0:KS-1][0:KS-1][DW-1:0]   win_q, win_d;
    logic [DW-1:0]                   lb_q [KS-1][IMG_W];

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        acc_col      = col_q;
        acc_row      = row_q;
        accept       = 1'b0;
        sync_err_d   = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pix_valid && pix_sof) begin
                    accept  = 1'b1;
                    state_d = ACTIVE;
                end else if (pix_valid) begin
                    sync_err_d = 1'b1;
                end
            end
            default: accept = pix_valid;
        endcase
        // SOF always restarts at the origin, including mid-frame aborts.
        if (pix_valid && pix_sof) begin
            acc_col = '0;
            acc_row = '0;
        end
        if (accept) begin
            if (acc_col == COL_LAST) begin
                col_d = '0;
                if (acc_row == ROW_LAST) begin
                    row_d        = '0;
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = acc_row + 1'b1;
                end
            end else begin
                col_d = acc_col + 1'b1;
                row_d = acc_row;
            end
        end
    end

    assign interior  = (int'(acc_row) >= KS - 1) && (int'(acc_col) >= KS - 1);
    assign raddr_d   = (AW'(acc_row) - AW'(KS / 2)) * AW'(IMG_W) + AW'(acc_col) - AW'(KS / 2);
    assign pix_ready = (state_q == ACTIVE);

    always_comb begin
        win_d = win_q;
        for (int r = 0; r < KS; r++)
            for (int c = 0; c < KS - 1; c++)
                win_d[r][c] = win_q[r][c+1];
        for (int r = 0; r < KS - 1; r++)
            win_d[r][KS-1] = lb_q[KS-2-r][acc_col];
        win_d[KS-1][KS-1] = pix_in;
    end

    // Line RAM: combinational read at acc_col, one column shifts down a line per accept.
    for (genvar k = 0; k < KS - 1; k++) begin : g_lb
        always_ff @(posedge clk) begin
            if (accept) begin
                if (k == 0) lb_q[k][acc_col] <= pix_in;
                else        lb_q[k][acc_col] <= lb_q[(k > 0) ? k - 1 : 0][acc_col];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            raddr_q      <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= accept && interior;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            if (accept) win_q <= win_d;
            if (accept && interior) raddr_q <= raddr_d;
        end
    end

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            frame_cnt_q <= '0;
        else if (frame_done_d) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
    assign frame_cnt = frame_cnt_q;
`endif

    assign win        = win_q;
    assign win_valid  = win_valid_q;
    assign raddr_alu  = raddr_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
endmodule

// File: tb/tb_line_window_buffer.sv
// Directed/random bench for line_window_buffer against an image-array reference model.
module tb_line_window_buffer;
    localparam int W = 8, H = 6, DW = 12, KS = 5, AW = 17;
    localparam int WW = KS * KS * DW;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic pix_valid = 1'b0, pix_sof = 1'b0;
    logic pix_ready, win_valid, frame_done, sync_err;
    logic [WW-1:0] win;
    logic [AW-1:0] raddr_alu;
`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    line_window_buffer #(.IMG_W(W), .IMG_H(H), .DW(DW), .KS(KS), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_ready(pix_ready), .win(win), .win_valid(win_valid), .raddr_alu(raddr_alu),
        .frame_done(frame_done),
`ifdef FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .sync_err(sync_err));

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    logic [DW-1:0] img [H][W];
    bit m_active = 0;
    int m_row = 0, m_col = 0;
    logic [AW-1:0] m_raddr = '0;
    logic [15:0] m_fcnt = '0;
    logic [WW-1:0] e_win, first_win;
    logic [AW-1:0] obs_q[$];
    int fd_cnt = 0;
    int exp_addr[8] = '{18, 19, 20, 21, 26, 27, 28, 29};

    task automatic chk(string tag, logic [WW-1:0] obs, logic [WW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] model_win(int r, int c);
        logic [WW-1:0] w = '0;
        for (int i = 0; i < KS; i++)
            for (int j = 0; j < KS; j++)
                w[(KS*KS-1-(i*KS+j))*DW +: DW] = img[r-KS+1+i][c-KS+1+j];
        return w;
    endfunction

    task automatic drive(bit v, bit s, logic [DW-1:0] p);
        int r, c;
        bit e_sync = 0, e_done = 0, e_wv = 0;
        @(negedge clk);
        pix_valid = v; pix_sof = s; pix_in = p;
        @(posedge clk); #1;
        if (v) begin
            if (!m_active && !s) e_sync = 1;
            else begin
                r = s ? 0 : m_row;
                c = s ? 0 : m_col;
                img[r][c] = p;
                m_active = 1;
                if (r >= KS - 1 && c >= KS - 1) begin
                    e_wv = 1;
                    m_raddr = AW'((r - KS/2) * W + c - KS/2);
                    e_win = model_win(r, c);
                end
                m_row = r; m_col = c + 1;
                if (c == W - 1) begin
                    m_col = 0;
                    m_row = r + 1;
                    if (r == H - 1) begin
                        m_row = 0; m_active = 0; e_done = 1; m_fcnt++;
                    end
                end
            end
        end
        chk("win_valid", WW'(win_valid), WW'(e_wv));
        chk("sync_err", WW'(sync_err), WW'(e_sync));
        chk("frame_done", WW'(frame_done), WW'(e_done));
        chk("pix_ready", WW'(pix_ready), WW'(m_active));
        chk("raddr_alu", WW'(raddr_alu), WW'(m_raddr));
        if (e_wv) chk("win", win, e_win);
`ifdef FRAME_CNT_EN
        chk("frame_cnt", WW'(frame_cnt), WW'(m_fcnt));
`endif
        if (win_valid) begin
            if (obs_q.size() == 0) first_win = win;
            obs_q.push_back(raddr_alu);
        end
        if (frame_done) fd_cnt++;
    endtask

    task automatic send_frame(int gap, bit rnd, int stop_r, int stop_c);
        logic [DW-1:0] p;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                while (int'($urandom_range(99)) < gap) drive(0, 0, DW'($urandom));
                p = rnd ? DW'($urandom) : {4'h0, 4'(r), 4'(c)};
                drive(1, (r == 0 && c == 0), p);
                if (r == stop_r && c == stop_c) return;
            end
    endtask

    task automatic check_addrs(string tag);
        chk({tag, "_count"}, WW'(obs_q.size()), WW'(8));
        for (int i = 0; i < 8; i++)
            chk({tag, "_addr"}, WW'((i < obs_q.size()) ? obs_q[i] : '1), WW'(exp_addr[i]));
    endtask

    initial begin
        #2;
        chk("rst_win_valid", WW'(win_valid), '0);
        chk("rst_pix_ready", WW'(pix_ready), '0);
        chk("rst_frame_done", WW'(frame_done), '0);
        chk("rst_sync_err", WW'(sync_err), '0);
        chk("rst_raddr", WW'(raddr_alu), '0);
        chk("rst_win", win, '0);
        @(negedge clk); rst_n = 1'b1;

        // Scenarios 1/2: pattern frame, no gaps
        obs_q.delete(); fd_cnt = 0;
        send_frame(0, 0, -1, -1);
        drive(0, 0, '0);
        check_addrs("s2");
        chk("s1_first_ms", WW'(first_win[WW-1 -: DW]), WW'(12'h000));
        chk("s1_first_ctr", WW'(first_win[(KS*KS/2)*DW +: DW]), WW'(12'h022));
        chk("s1_first_ls", WW'(first_win[DW-1:0]), WW'(12'h044));
        chk("s2_frame_done", WW'(fd_cnt), WW'(1));

        // Scenario 3: random pixels with ~50% gaps
        obs_q.delete();
        send_frame(50, 1, -1, -1);
        drive(0, 0, '0);
        check_addrs("s3");

        // Scenario 4: stray pixel in IDLE, then mid-frame SOF restart
        drive(1, 0, 12'h5a5);
        drive(0, 0, '0);
        obs_q.delete(); fd_cnt = 0;
        send_frame(10, 1, 3, 1);
        send_frame(10, 1, -1, -1);
        drive(0, 0, '0);
        check_addrs("s4");
        chk("s4_frame_done", WW'(fd_cnt), WW'(1));

        // Scenario 5: async reset mid-frame
        send_frame(0, 1, 4, 6);
        rst_n = 1'b0; #1;
        chk("s5_win_valid", WW'(win_valid), '0);
        chk("s5_frame_done", WW'(frame_done), '0);
        chk("s5_pix_ready", WW'(pix_ready), '0);
        m_active = 0; m_row = 0; m_col = 0; m_raddr = '0; m_fcnt = '0;
        @(negedge clk); pix_valid = 1'b0; pix_sof = 1'b0; rst_n = 1'b1;
        obs_q.delete();
        send_frame(20, 1, -1, -1);
        check_addrs("s5");

        // Scenario 6: two more full frames and one aborted frame
        send_frame(0, 1, -1, -1);
        send_frame(30, 1, -1, -1);
        send_frame(0, 1, 2, 3);
        drive(0, 0, '0);
`ifdef FRAME_CNT_EN
        chk("s6_frame_cnt", WW'(frame_cnt), WW'(3));
`endif
        drive(0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
